// File: rtl/logic_chip_tester.sv
// Built-in tester for quad/hex 74hc-style gate models: sweeps every input
// pattern, waits a settle interval, and compares outputs against INV or XOR.
module logic_chip_tester #(
   parameter int CHANNELS = 4,
   parameter int SETTLE   = 2,
   parameter int ERR_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  mode,
   output logic [CHANNELS-1:0]   stim_a,
   output logic [CHANNELS-1:0]   stim_b,
   input  logic [CHANNELS-1:0]   dut_y,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      err_count,
   output logic [CHANNELS-1:0]   fail_mask,
   output logic [2*CHANNELS-1:0] first_fail_vec,
   output logic                  first_fail_valid
);

   localparam int VW = 2 * CHANNELS;
   localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE);
   localparam logic [VW-1:0]    LAST_INV    = {{CHANNELS{1'b0}}, {CHANNELS{1'b1}}};
   localparam logic [VW-1:0]    LAST_XOR    = '1;
   localparam logic [ERR_W-1:0] ERR_MAX     = '1;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

   state_t              r_state;
   logic [VW-1:0]       r_cnt;
   logic [SW-1:0]       r_settle;
   logic                r_mode;
   logic [ERR_W-1:0]    r_err;
   logic [CHANNELS-1:0] r_mask;
   logic [VW-1:0]       r_firstVec;
   logic                r_firstValid;
   logic                r_busy;
   logic                r_done;
   logic                r_pass;

   logic [CHANNELS-1:0] w_expected;
   logic [CHANNELS-1:0] w_mis;
   logic [ERR_W-1:0]    w_errNext;
   logic                w_isLast;

   // In INV mode the upper half of the counter never moves, so stim_b stays 0.
   assign stim_a     = r_cnt[CHANNELS-1:0];
   assign stim_b     = r_mode ? r_cnt[VW-1:CHANNELS] : '0;
   assign w_expected = r_mode ? (stim_a ^ stim_b) : ~stim_a;
   assign w_mis      = dut_y ^ w_expected;
   assign w_errNext  = ((w_mis == '0) || (r_err == ERR_MAX)) ? r_err : r_err + ERR_W'(1);
   assign w_isLast   = (r_cnt == (r_mode ? LAST_XOR : LAST_INV));

   assign busy             = r_busy;
   assign done             = r_done;
   assign pass             = r_pass;
   assign err_count        = r_err;
   assign fail_mask        = r_mask;
   assign first_fail_vec   = r_firstVec;
   assign first_fail_valid = r_firstValid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_settle     <= '0;
         r_mode       <= 1'b0;
         r_err        <= '0;
         r_mask       <= '0;
         r_firstVec   <= '0;
         r_firstValid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
      end else if (abort) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_settle     <= '0;
         r_mode       <= 1'b0;
         r_err        <= '0;
         r_mask       <= '0;
         r_firstVec   <= '0;
         r_firstValid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state      <= S_SETTLE;
                  r_mode       <= mode;
                  r_cnt        <= '0;
                  r_settle     <= SETTLE_LOAD;
                  r_err        <= '0;
                  r_mask       <= '0;
                  r_firstVec   <= '0;
                  r_firstValid <= 1'b0;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
                  r_pass       <= 1'b0;
               end
            end
            S_SETTLE: begin
               if (r_settle == SW'(1)) begin
                  r_state <= S_CHECK;
               end else begin
                  r_settle <= r_settle - SW'(1);
               end
            end
            S_CHECK: begin
               r_err  <= w_errNext;
               r_mask <= r_mask | w_mis;
               if ((w_mis != '0) && !r_firstValid) begin
                  r_firstVec   <= r_cnt;
                  r_firstValid <= 1'b1;
               end
               // pass is taken from the post-update count so it is valid with done.
               if (w_isLast) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_errNext == '0);
               end else begin
                  r_state  <= S_SETTLE;
                  r_cnt    <= r_cnt + VW'(1);
                  r_settle <= SETTLE_LOAD;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/logic_chip_tester.md
Name: logic_chip_tester

Overview:
- Parametrised built-in tester for quad/hex logic-gate chip models of the 74hc family.
- Sweeps every input pattern across CHANNELS gates, waits a settle interval, and compares the DUT outputs against an internal golden function selected by mode (INV or XOR).
- Reports pass/fail, a saturating error count, a per-channel fail mask and the first failing vector.
- Sits between a chip model and the top-level regression bench, and replaces fixed-delay, manually inspected benches.

Parameters:
- CHANNELS, 4: number of gates per chip (4 for 74hc86, 6 for 74hc04); range 1..8.
- SETTLE, 2: cycles the stimulus is held before sampling; must be ≥1.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a sweep from IDLE or DONE.
- abort  input  1  returns to IDLE from any state.
- mode  input  1  0 = INV (y = ~a), 1 = XOR (y = a ^ b); latched on accepted start.
- stim_a  output  CHANNELS  gate input A per channel.
- stim_b  output  CHANNELS  gate input B per channel; 0 in INV mode.
- dut_y  input  CHANNELS  DUT gate outputs.
- busy  output  1  high in SETTLE and CHECK.
- done  output  1  high in DONE.
- pass  output  1  valid when done; 1 iff err_count == 0.
- err_count  output  ERR_W  number of failing vectors, saturating.
- fail_mask  output  CHANNELS  OR of mismatching channels over the run.
- first_fail_vec  output  2*CHANNELS  vector index of the first failing check.
- first_fail_valid  output  1  first_fail_vec is captured.

Behaviour:
- **Reset:** rst high asynchronously forces state IDLE. The vector counter cnt (2*CHANNELS bits), settle counter, latched mode, err_count, fail_mask, first_fail_vec, first_fail_valid, busy, done and pass all go to 0.
- **Stimulus** (combinational from cnt and latched mode):
  - stim_a = cnt[CHANNELS-1:0].
  - stim_b = cnt[2*CHANNELS-1:CHANNELS] in XOR mode, else 0.
- **Last vector:** 2^CHANNELS-1 in INV mode, 2^(2*CHANNELS)-1 in XOR mode.
- **Expected output:** INV gives ~stim_a; XOR gives stim_a ^ stim_b. mis = dut_y XOR expected.
- **IDLE:**
  - On start: latch mode, clear cnt, err_count, fail_mask and first_fail_*; load settle counter with SETTLE; go to SETTLE.
- **SETTLE:**
  - Decrement the settle counter each cycle.
  - When it reaches 1 (after SETTLE cycles in the state), go to CHECK.
- **CHECK** (exactly 1 cycle):
  - Sample dut_y and compute mis.
  - If mis ≠ 0:
    - err_count increments, saturating at 2^ERR_W-1.
    - fail_mask |= mis.
    - If first_fail_valid = 0, capture first_fail_vec = cnt and set first_fail_valid = 1.
  - If cnt = last vector, go to DONE with cnt held.
  - Otherwise cnt++, reload SETTLE, and go to SETTLE.
- **Latency:** each vector costs SETTLE+1 cycles. A full sweep takes N*(SETTLE+1) cycles from start to done rising, where N is the vector count.
- **DONE:**
  - done = 1 and pass = (err_count == 0). Results and stimulus hold.
  - start re-arms exactly as from IDLE (results cleared on the same edge).
- **Guards:**
  - start during SETTLE/CHECK is ignored.
  - abort wins over start in the same cycle.
  - abort leaves IDLE with cnt = 0; results are cleared and done = 0.
- **Mode:** a mode change mid-run has no effect until the next accepted start.
- **Reset mid-run:** identical to power-on reset; no partial results survive.

Test Plan:
1. Correct INV model, CHANNELS=4, SETTLE=2, mode=0, start → 16 vectors; done rises 48 cycles after start; pass=1, err_count=0, fail_mask=0000, first_fail_valid=0.
2. Correct XOR model, mode=1 → 256 vectors; done rises at 768 cycles; pass=1. Spot-check: cnt=0x35 drives stim_a=0101, stim_b=0011.
3. XOR model with channel 2 stuck-at-0 → err_count=128, fail_mask=0100, first_fail_vec=0x04, first_fail_valid=1, pass=0.
4. INV model with channel 0 stuck-at-1 → err_count=8, fail_mask=0001, first_fail_vec=0x01. Rerun with ERR_W=2 → err_count saturates at 3, pass=0.
5. Protocol checks:
   - abort in cycle 20 of a XOR sweep → IDLE next cycle, busy=0, done=0, stim=0.
   - start and abort in the same cycle → stays IDLE.
   - start pulsed mid-run → ignored; total latency unchanged.
6. Reset and restart:
   - rst asserted mid-sweep, asynchronously between edges → all outputs 0 immediately.
   - After DONE with errors, start with a correct model → err_count cleared on the start edge; pass=1 at the new done.
